cmat2x2_sequencer: RTL and testbench

Control and accumulation stage for the 2x2 complex matrix product C = A·B. It accepts the eight complex elements of A and B as a serial stream and buffers them. It then drives the combinational complex multiplier stage with the eight required operand pairs, one pair per cycle, and sums its products pairwise into the four C elements. The results are emitted as a serial valid/ready stream, so the multiplier sits between this block's `mul_*` outputs and `mul_p_*` inputs.

---
 rtl/cmat2x2_sequencer.sv | 157 +++++++++++++++
 tb/tb_cmat2x2_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmat2x2_sequencer.sv
// Sequencer and accumulator for the 2x2 complex matrix product C = A*B.
// Buffers A and B from a serial stream, feeds an external multiplier one pair per cycle, streams C out.
module cmat2x2_sequencer #(
  parameter int DATA_W = 8,
  parameter int PROD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic [DATA_W-1:0] mul_a_re,
  output logic [DATA_W-1:0] mul_a_im,
  output logic [DATA_W-1:0] mul_b_re,
  output logic [DATA_W-1:0] mul_b_im,
  input  logic [PROD_W-1:0] mul_p_re,
  input  logic [PROD_W-1:0] mul_p_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W:0]   out_re,
  output logic [PROD_W:0]   out_im,
  output logic              out_last,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid-side data is held stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] a_re [4];
  logic [DATA_W-1:0] a_im [4];
  logic [DATA_W-1:0] b_re [4];
  logic [DATA_W-1:0] b_im [4];
  logic [PROD_W:0]   c_re [4];
  logic [PROD_W:0]   c_im [4];
  logic [PROD_W:0]   acc_re, acc_im;
  logic [PROD_W:0]   p_re_ext, p_im_ext;
  logic [2:0]        load_cnt;
  logic [2:0]        k;
  logic [1:0]        out_idx;
  logic [1:0]        a_sel, b_sel;

  assign dbg_state = state;

  // Step k: C index e = k[2:1] (i = k[2], j = k[1]), inner index m = k[0].
  assign a_sel    = {k[2], k[0]};
  assign b_sel    = {k[0], k[1]};
  assign p_re_ext = {mul_p_re[PROD_W-1], mul_p_re};
  assign p_im_ext = {mul_p_im[PROD_W-1], mul_p_im};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && load_cnt == 3'd7) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        busy = 1'b1;
        if (k == 3'd7) state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (out_idx == 2'd3);
        if (out_ready && out_idx == 2'd3) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    mul_a_re = '0;
    mul_a_im = '0;
    mul_b_re = '0;
    mul_b_im = '0;
    out_re   = '0;
    out_im   = '0;
    if (state == S_COMPUTE) begin
      mul_a_re = a_re[a_sel];
      mul_a_im = a_im[a_sel];
      mul_b_re = b_re[b_sel];
      mul_b_im = b_im[b_sel];
    end
    if (state == S_OUTPUT) begin
      out_re = c_re[out_idx];
      out_im = c_im[out_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        a_re[n] <= '0;
        a_im[n] <= '0;
        b_re[n] <= '0;
        b_im[n] <= '0;
        c_re[n] <= '0;
        c_im[n] <= '0;
      end
      acc_re   <= '0;
      acc_im   <= '0;
      load_cnt <= '0;
      k        <= '0;
      out_idx  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            // Elements arrive A00..A11 then B00..B11; load_cnt wraps to 0 after the 8th.
            if (!load_cnt[2]) begin
              a_re[load_cnt[1:0]] <= in_re;
              a_im[load_cnt[1:0]] <= in_im;
            end else begin
              b_re[load_cnt[1:0]] <= in_re;
              b_im[load_cnt[1:0]] <= in_im;
            end
            load_cnt <= load_cnt + 3'd1;
          end
        end
        S_COMPUTE: begin
          if (!k[0]) begin
            acc_re <= p_re_ext;
            acc_im <= p_im_ext;
          end else begin
            c_re[k[2:1]] <= acc_re + p_re_ext;
            c_im[k[2:1]] <= acc_im + p_im_ext;
          end
          k <= k + 3'd1;
        end
        S_OUTPUT: begin
          if (out_ready) out_idx <= out_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmat2x2_sequencer.sv
// Directed bench for cmat2x2_sequencer with a behavioural complex multiplier in the loop.
module tb_cmat2x2_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic        [7:0]  in_re, in_im;
  logic signed [7:0]  mul_a_re, mul_a_im, mul_b_re, mul_b_im;
  logic        [15:0] mul_p_re, mul_p_im;
  logic               out_valid;
  logic               out_ready;
  logic signed [16:0] out_re, out_im;
  logic               out_last;
  logic               busy;
  logic        [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_edge, last_edge;
  int m_re [8];
  int m_im [8];
  logic [34:0] exp_q [$];
  int pr_i, pi_i;

  cmat2x2_sequencer #(.DATA_W(8), .PROD_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .mul_a_re(mul_a_re), .mul_a_im(mul_a_im), .mul_b_re(mul_b_re), .mul_b_im(mul_b_im),
    .mul_p_re(mul_p_re), .mul_p_im(mul_p_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // External combinational complex multiplier, truncated to 16 bits
  assign pr_i     = mul_a_re * mul_b_re - mul_a_im * mul_b_im;
  assign pi_i     = mul_a_re * mul_b_im + mul_a_im * mul_b_re;
  assign mul_p_re = pr_i[15:0];
  assign mul_p_im = pi_i[15:0];

  // Driver tasks
  task automatic push_exp(input int re, input int im, input bit last);
    logic [16:0] r17, i17;
    r17 = 17'(re);
    i17 = 17'(im);
    exp_q.push_back({last, r17, i17});
  endtask

  task automatic set_identity_b();
    m_re = '{1, 0, 0, 1, 1, 3, -4, 0};
    m_im = '{0, 0, 0, 0, 2, -1, 0, 5};
  endtask

  task automatic push_identity_exp();
    push_exp(1, 2, 0);
    push_exp(3, -1, 0);
    push_exp(-4, 0, 0);
    push_exp(0, 5, 1);
  endtask

  task automatic load_mats(input bit bubbles);
    for (int n = 0; n < 8; n++) begin
      if (bubbles && n > 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_re    = 8'(m_re[n]);
      in_im    = 8'(m_im[n]);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready n=%0d in_ready=%b expected 1", n, in_ready);
      end
      if (n == 0) start_edge = cyc + 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
  endtask

  // Called at the negedge just after the 8th accept edge.
  task automatic check_latency();
    int cnt;
    cnt = 0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL compute_flags busy=%b in_ready=%b expected busy=1 in_ready=0", busy, in_ready);
    end
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL latency edges_to_out_valid=%0d expected 8", cnt);
    end
  endtask

  // Scoreboard: drain four results, optionally with backpressure
  task automatic collect(input bit bp);
    int vc, got, guard;
    bit held;
    logic [34:0] hv, cur, e;
    vc = 0; got = 0; guard = 0; held = 1'b0; hv = '0;
    while (got < 4 && guard < 100) begin
      cur = {out_last, out_re, out_im};
      if (held) begin
        checks++;
        if (cur !== hv || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_stable got=%h valid=%b expected=%h valid=1", cur, out_valid, hv);
        end
      end
      if (out_valid === 1'b1) begin
        out_ready = bp ? (vc >= 5 && ((vc - 5) % 2 == 0)) : 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_during_output got=%b expected 0", in_ready);
        end
        if (out_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          checks++;
          if (cur !== e) begin
            errors++;
            $display("FAIL out_data idx=%0d got re=%0d im=%0d last=%b expected re=%0d im=%0d last=%b",
                     got, $signed(cur[33:17]), $signed(cur[16:0]), cur[34],
                     $signed(e[33:17]), $signed(e[16:0]), e[34]);
          end
          got++;
          held = 1'b0;
          if (got == 4) last_edge = cyc + 1;
        end else begin
          held = 1'b1;
          hv   = cur;
        end
        vc++;
      end else begin
        out_ready = !bp;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b1;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL output_timeout got=%0d expected 4", got);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_c11 in_ready=%b out_valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        out_re !== 17'd0 || out_im !== 17'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs in_ready=%b out_valid=%b last=%b busy=%b re=%0d im=%0d st=%0d expected 1 0 0 0 0 0 0",
               in_ready, out_valid, out_last, busy, out_re, out_im, dbg_state);
    end
    checks++;
    if ({mul_a_re, mul_a_im, mul_b_re, mul_b_im} !== 32'd0) begin
      errors++;
      $display("FAIL reset_mul got=%h expected 0", {mul_a_re, mul_a_im, mul_b_re, mul_b_im});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    set_identity_b();
    push_identity_exp();
    load_mats(1'b0);
    check_latency();
    collect(1'b0);
  endtask

  task automatic test_general();
    m_re = '{1, 2, 0, 0, 0, 1, 1, 1};
    m_im = '{1, 0, 0, 1, 1, 0, 0, 0};
    push_exp(1, 1, 0);
    push_exp(3, 1, 0);
    push_exp(0, 1, 0);
    push_exp(0, 1, 1);
    load_mats(1'b0);
    check_latency();
    collect(1'b0);
  endtask

  task automatic test_width();
    for (int n = 0; n < 8; n++) begin
      m_re[n] = 127;
      m_im[n] = 127;
    end
    for (int n = 0; n < 4; n++) push_exp(0, 64516, n == 3);
    load_mats(1'b0);
    check_latency();
    collect(1'b0);
  endtask

  task automatic test_backpressure();
    set_identity_b();
    push_identity_exp();
    load_mats(1'b0);
    check_latency();
    collect(1'b1);
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_identity_b();
    load_mats(1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (mul_b_im !== 8'sd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_k3 mul_b_im=%0d busy=%b expected 5 1", mul_b_im, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        {mul_a_re, mul_a_im, mul_b_re, mul_b_im} !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset out_valid=%b in_ready=%b busy=%b mul=%h expected 0 1 0 0",
               out_valid, in_ready, busy, {mul_a_re, mul_a_im, mul_b_re, mul_b_im});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL stale_after_reset got activity=1 expected 0");
    end
    push_identity_exp();
    load_mats(1'b0);
    check_latency();
    collect(1'b0);
  endtask

  task automatic test_back_to_back();
    m_re = '{1, 2, 0, 0, 0, 1, 1, 1};
    m_im = '{1, 0, 0, 1, 1, 0, 0, 0};
    push_exp(1, 1, 0);
    push_exp(3, 1, 0);
    push_exp(0, 1, 0);
    push_exp(0, 1, 1);
    load_mats(1'b1);
    check_latency();
    collect(1'b0);
    set_identity_b();
    push_identity_exp();
    load_mats(1'b0);
    check_latency();
    collect(1'b0);
    checks++;
    if (last_edge - start_edge + 1 != 20) begin
      errors++;
      $display("FAIL period got=%0d expected 20", last_edge - start_edge + 1);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_general();
    test_width();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
